// File: rtl/sgm_pkg.sv
// Shared definitions for the SGM path aggregation slice.
// Contents: aggregation direction encodings, ceil-log2 helper,
// predecessor distance per direction, guard-bit rule for saturating sums.
package sgm_pkg;

   localparam int unsigned DIR_LR   = 0;  // left to right
   localparam int unsigned DIR_TB   = 1;  // top to bottom
   localparam int unsigned DIR_TLBR = 2;  // top-left diagonal
   localparam int unsigned DIR_TRBL = 3;  // top-right diagonal

   // Intermediate path sums carry two extra bits so C + S - m never wraps
   // before the final clip to ACC_COST_BITS.
   localparam int unsigned SAT_GUARD_BITS = 2;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   // Number of valid pixels between a pixel and its path predecessor.
   function automatic int unsigned predecessor_distance(input int unsigned direction,
                                                        input int unsigned width);
      int unsigned d;
      case (direction)
         DIR_TB:   d = width;
         DIR_TLBR: d = width + 1;
         DIR_TRBL: d = width - 1;
         default:  d = 1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/min_reduce_tree.sv
// Combinational minimum over INPUTS packed WIDTH-bit values.
// Ports: in_data (INPUTS*WIDTH, element i at [WIDTH*i +: WIDTH]),
//        out_min_c (WIDTH, minimum value; no index).
module min_reduce_tree
   import sgm_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned INPUTS = 4
) (
   input  logic [WIDTH*INPUTS-1:0] in_data,
   output logic [WIDTH-1:0]        out_min_c
);

   localparam int unsigned LEVELS = (INPUTS > 1) ? clog2(INPUTS) : 1;
   localparam int unsigned LEAVES = 32'(1) << LEVELS;

   // One generate scope per tree level; unused leaves pad with all-ones.
   for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
      logic [WIDTH-1:0] v [LEAVES >> l];
      if (l == 0) begin : g_leaves
         for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
            if (i < INPUTS) begin : g_in
               assign v[i] = in_data[WIDTH*i +: WIDTH];
            end else begin : g_pad
               assign v[i] = '1;
            end
         end
      end else begin : g_cmp
         for (genvar i = 0; i < (LEAVES >> l); i++) begin : g_node
            assign v[i] = (g_lvl[l-1].v[2*i] < g_lvl[l-1].v[2*i+1]) ?
                          g_lvl[l-1].v[2*i] : g_lvl[l-1].v[2*i+1];
         end
      end
   end

   assign out_min_c = g_lvl[LEVELS].v[0];

endmodule

// File: rtl/ram_delay_line.sv
// Clock-enabled delay line: out_data_c shows the word written DEPTH enables ago.
// Ports: in_clk, in_rst_n (async, active low), in_ce (advance),
//        in_data (written on in_ce), out_data_c (asynchronous read of oldest word).
module ram_delay_line
   import sgm_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 2
) (
   input  logic                  in_clk,
   input  logic                  in_rst_n,
   input  logic                  in_ce,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [DATA_WIDTH-1:0] out_data_c
);

   localparam int unsigned PTR_BITS = (DEPTH > 1) ? clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_BITS-1:0]   ptr_q;

   // Read-before-write at the same slot yields a DEPTH-enable delay.
   assign out_data_c = mem[ptr_q];

   // Storage has no reset; contents are masked by the consumer after reset.
   always_ff @(posedge in_clk) begin
      if (in_ce) mem[ptr_q] <= in_data;
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         ptr_q <= '0;
      end else if (in_ce) begin
         ptr_q <= (ptr_q == PTR_BITS'(DEPTH - 1)) ? '0 : ptr_q + PTR_BITS'(1);
      end
   end

endmodule

// File: rtl/sgm_path_aggregator.sv
// SGM single-direction path cost aggregator, one pixel per cycle, latency 1.
// Ports: in_clk, in_rst_n (async, active low), in_valid, in_sof,
//        in_P1/in_P2 penalties, in_C_arr local costs (d at [COST_BITS*d +: COST_BITS]),
//        out_valid, out_L_arr path costs (same packing), out_min_L (min over d).
module sgm_path_aggregator
   import sgm_pkg::*;
#(
   parameter int unsigned DISPARITY_LEVELS = 64,
   parameter int unsigned COST_BITS        = 6,
   parameter int unsigned ACC_COST_BITS    = 10,
   parameter int unsigned PENALTY_BITS     = 6,
   parameter int unsigned IMG_WIDTH        = 640,
   parameter int unsigned DIRECTION        = 0
) (
   input  logic                                  in_clk,
   input  logic                                  in_rst_n,
   input  logic                                  in_valid,
   input  logic                                  in_sof,
   input  logic [PENALTY_BITS-1:0]               in_P1,
   input  logic [PENALTY_BITS-1:0]               in_P2,
   input  logic [COST_BITS*DISPARITY_LEVELS-1:0] in_C_arr,
   output logic                                  out_valid,
   output logic [ACC_COST_BITS*DISPARITY_LEVELS-1:0] out_L_arr,
   output logic [ACC_COST_BITS-1:0]              out_min_L
);

   localparam int unsigned DL = DISPARITY_LEVELS;
   localparam int unsigned CB = COST_BITS;
   localparam int unsigned AB = ACC_COST_BITS;
   localparam int unsigned WB = AB + SAT_GUARD_BITS;
   localparam int unsigned XB = clog2(IMG_WIDTH);
   localparam int unsigned LINE_DEPTH = predecessor_distance(DIRECTION, IMG_WIDTH) - 1;
   localparam logic [WB-1:0] SAT_MAX = {{SAT_GUARD_BITS{1'b0}}, {AB{1'b1}}};

   if (ACC_COST_BITS < COST_BITS) begin : g_bad_acc
      $error("ACC_COST_BITS must be >= COST_BITS");
   end
   if (PENALTY_BITS > ACC_COST_BITS) begin : g_bad_pen
      $error("PENALTY_BITS must be <= ACC_COST_BITS");
   end
   if (DISPARITY_LEVELS < 2 || IMG_WIDTH < 3 || DIRECTION > 3) begin : g_bad_geom
      $error("DISPARITY_LEVELS >= 2, IMG_WIDTH >= 3, DIRECTION in 0..3 required");
   end

   logic [XB-1:0]      x_q;
   logic               first_row_q;
   logic [XB-1:0]      x_cur_c;
   logic               first_row_cur_c;
   logic               last_col_c;
   logic               border_c;
   logic [AB*DL-1:0]   lp_arr_c;
   logic [AB-1:0]      lp_min_c;
   logic [AB*DL-1:0]   l_next_c;
   logic [AB-1:0]      l_min_c;

   // Position of the pixel currently on the inputs; in_sof overrides the counters.
   always_comb begin
      x_cur_c         = in_sof ? '0 : x_q;
      first_row_cur_c = in_sof | first_row_q;
      last_col_c      = (x_cur_c == XB'(IMG_WIDTH - 1));
      border_c        = 1'b0;
      if (DIRECTION == DIR_LR)        border_c = (x_cur_c == '0);
      else if (DIRECTION == DIR_TB)   border_c = first_row_cur_c;
      else if (DIRECTION == DIR_TLBR) border_c = first_row_cur_c | (x_cur_c == '0);
      else                            border_c = first_row_cur_c | last_col_c;
   end

   // Predecessor: the output register itself, or a delay line fed from it.
   if (DIRECTION == DIR_LR) begin : g_pred_reg
      assign lp_arr_c = out_L_arr;
      assign lp_min_c = out_min_L;
   end else begin : g_pred_line
      logic [AB*(DL+1)-1:0] pred_word_c;
      ram_delay_line #(
         .DATA_WIDTH(AB*(DL+1)),
         .DEPTH     (LINE_DEPTH)
      ) u_line (
         .in_clk    (in_clk),
         .in_rst_n  (in_rst_n),
         .in_ce     (in_valid),
         .in_data   ({out_min_L, out_L_arr}),
         .out_data_c(pred_word_c)
      );
      assign lp_arr_c = pred_word_c[AB*DL-1:0];
      assign lp_min_c = pred_word_c[AB*(DL+1)-1 -: AB];
   end

   // Path recursion with saturation; borders pass the local cost through.
   always_comb begin
      logic [WB-1:0] m_w, s_w, cand_w, l_w;
      l_next_c = '0;
      m_w      = WB'(lp_min_c);
      s_w      = '0;
      cand_w   = '0;
      l_w      = '0;
      for (int d = 0; d < DL; d++) begin
         s_w = WB'(lp_arr_c[AB*d +: AB]);
         if (d > 0) begin
            cand_w = WB'(lp_arr_c[AB*((d > 0) ? d - 1 : 0) +: AB]) + WB'(in_P1);
            if (cand_w < s_w) s_w = cand_w;
         end
         if (d < DL - 1) begin
            cand_w = WB'(lp_arr_c[AB*((d < DL - 1) ? d + 1 : d) +: AB]) + WB'(in_P1);
            if (cand_w < s_w) s_w = cand_w;
         end
         cand_w = m_w + WB'(in_P2);
         if (cand_w < s_w) s_w = cand_w;
         l_w = WB'(in_C_arr[CB*d +: CB]) + s_w - m_w;
         if (border_c)            l_next_c[AB*d +: AB] = AB'(in_C_arr[CB*d +: CB]);
         else if (l_w > SAT_MAX)  l_next_c[AB*d +: AB] = '1;
         else                     l_next_c[AB*d +: AB] = AB'(l_w);
      end
   end

   min_reduce_tree #(
      .WIDTH (AB),
      .INPUTS(DL)
   ) u_min (
      .in_data  (l_next_c),
      .out_min_c(l_min_c)
   );

   // Output and position registers advance only on valid pixels.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         out_valid   <= 1'b0;
         out_L_arr   <= '0;
         out_min_L   <= '0;
         x_q         <= '0;
         first_row_q <= 1'b1;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_L_arr   <= l_next_c;
            out_min_L   <= l_min_c;
            x_q         <= last_col_c ? '0 : x_cur_c + XB'(1);
            first_row_q <= first_row_cur_c & ~last_col_c;
         end
      end
   end

endmodule
